// File: rtl/mdu_seq_ctrl_if.sv
// Issue/result bundle between the EX-stage pipeline control and the MDU sequencer.
// Data vectors use [0:WIDTH-1] numbering: bit 0 is the MSB.
interface mdu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [0:WIDTH-1] rA;
  logic [0:WIDTH-1] rB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [0:WIDTH-1] result;
  logic [3:0]       D;

  modport master (
    output start, op, rA, rB, flush,
    input  busy, done, result, D
  );

  modport slave (
    input  start, op, rA, rB, flush,
    output busy, done, result, D
  );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer: latches one op, runs a fixed-latency multiply or a radix-2
// restoring divide, then pulses done with the result and the {OV, LT, GT, EQ} flag word.
module mdu_seq_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  mdu_seq_ctrl_if.slave bus
);

  localparam logic [2:0] OpMullw  = 3'b000;
  localparam logic [2:0] OpMulhw  = 3'b001;
  localparam logic [2:0] OpMulhwu = 3'b010;
  localparam logic [2:0] OpDivw   = 3'b100;
  localparam logic [2:0] OpDivwu  = 3'b101;

  localparam int unsigned MaxIter = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxIter) + 1;
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  // Internal vectors are descending, so the MSB sits at index WIDTH-1.
  logic [WIDTH-1:0]   a_in, b_in, a_abs, b_abs;
  logic               a_neg, b_neg, divw_special;
  logic [2*WIDTH-1:0] a_x, b_x, prod;
  logic               mul_ov;
  logic [WIDTH:0]     rem_sh, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_nxt, rem_nxt, quo_fin;

  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] r, input logic ov);
    logic lt, eq;
    lt = r[WIDTH-1];
    eq = (r == '0);
    return {ov, lt, !lt && !eq, eq};
  endfunction

  assign a_in = bus.rA;
  assign b_in = bus.rB;

  always_comb begin
    a_neg        = a_in[WIDTH-1];
    b_neg        = b_in[WIDTH-1];
    a_abs        = a_neg ? -a_in : a_in;
    b_abs        = b_neg ? -b_in : b_in;
    divw_special = (b_in == '0) ||
                   ((a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (b_in == '1));

    // One multiplier; mulhwu zero-extends, the signed ops sign-extend.
    if (op_q == OpMulhwu) begin
      a_x = {{WIDTH{1'b0}}, a_q};
      b_x = {{WIDTH{1'b0}}, b_q};
    end else begin
      a_x = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      b_x = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end
    prod   = a_x * b_x;
    mul_ov = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

    // Restoring step: a_q shifts dividend bits out and quotient bits in.
    rem_sh  = {rem_q, a_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_q};
    q_bit   = ~diff[WIDTH];
    quo_nxt = {a_q[WIDTH-2:0], q_bit};
    rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_fin = neg_q ? -quo_nxt : quo_nxt;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.op;
          cnt_d = '0;
          rem_d = '0;
          neg_d = 1'b0;
          a_d   = a_in;
          b_d   = b_in;
          case (bus.op)
            OpMullw, OpMulhw, OpMulhwu: state_d = StMul;
            OpDivw: begin
              if (divw_special) begin
                state_d  = StDone;
                done_d   = 1'b1;
                result_d = '0;
                flags_d  = calc_flags('0, 1'b1);
              end else begin
                a_d     = a_abs;
                b_d     = b_abs;
                neg_d   = a_neg ^ b_neg;
                state_d = StDiv;
              end
            end
            OpDivwu: begin
              if (b_in == '0) begin
                state_d  = StDone;
                done_d   = 1'b1;
                result_d = '0;
                flags_d  = calc_flags('0, 1'b1);
              end else begin
                state_d = StDiv;
              end
            end
            default: begin
              state_d  = StDone;
              done_d   = 1'b1;
              result_d = '0;
              flags_d  = calc_flags('0, 1'b0);
            end
          endcase
        end
      end
      StMul: begin
        if (cnt_q == MulLast) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = (op_q == OpMullw) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          flags_d  = calc_flags(result_d, (op_q == OpMullw) && mul_ov);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        a_d   = quo_nxt;
        rem_d = rem_nxt;
        if (cnt_q == DivLast) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = quo_fin;
          flags_d  = calc_flags(quo_fin, 1'b0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A killed op never completes and never disturbs the last published result.
    if (bus.flush) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
      flags_d  = flags_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.D      = flags_q;

endmodule
